leds: RTL and testbench

//  Drives the board's eight user LEDs (LED0..LED7) from an internal registered

---
 rtl/leds.sv | 50 +++++
 tb/tb_leds.sv | 116 +++++++++++
 2 files changed

// File: rtl/leds.sv
// Board LED driver: shows a registered 8-bit image on LED0..LED7,
// optionally rotating it left once every DIV clock cycles.
module leds #(
   parameter logic [7:0]  PATTERN   = 8'h55,
   parameter bit          ROTATE_EN = 1'b0,
   parameter int unsigned DIV       = 1
) (
   input  logic clk,
   input  logic rst,
   output logic LED0,
   output logic LED1,
   output logic LED2,
   output logic LED3,
   output logic LED4,
   output logic LED5,
   output logic LED6,
   output logic LED7
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [7:0]    pat;
   logic [CW-1:0] cnt;

   // cnt wraps at DIV-1, so it can never overflow its width
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pat <= PATTERN;
         cnt <= '0;
      end else if (ROTATE_EN) begin
         if (cnt == LAST) begin
            cnt <= '0;
            pat <= {pat[6:0], pat[7]};
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign LED0 = pat[0];
   assign LED1 = pat[1];
   assign LED2 = pat[2];
   assign LED3 = pat[3];
   assign LED4 = pat[4];
   assign LED5 = pat[5];
   assign LED6 = pat[6];
   assign LED7 = pat[7];

endmodule

// File: tb/tb_leds.sv
// Directed bench for leds: six parameter sets, each with its own reset.
module tb_leds;

   logic clk = 1'b0;
   logic r1 = 1'b0, r2 = 1'b0, r3 = 1'b0;
   logic r4 = 1'b0, r5 = 1'b0, r6 = 1'b0;
   wire [7:0] o1, o2, o3, o4, o5, o6;
   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   leds u1 (.clk(clk), .rst(r1),
      .LED0(o1[0]), .LED1(o1[1]), .LED2(o1[2]), .LED3(o1[3]),
      .LED4(o1[4]), .LED5(o1[5]), .LED6(o1[6]), .LED7(o1[7]));

   leds #(.PATTERN(8'h01), .ROTATE_EN(1'b1), .DIV(1)) u2 (
      .clk(clk), .rst(r2),
      .LED0(o2[0]), .LED1(o2[1]), .LED2(o2[2]), .LED3(o2[3]),
      .LED4(o2[4]), .LED5(o2[5]), .LED6(o2[6]), .LED7(o2[7]));

   leds #(.PATTERN(8'h81), .ROTATE_EN(1'b1), .DIV(4)) u3 (
      .clk(clk), .rst(r3),
      .LED0(o3[0]), .LED1(o3[1]), .LED2(o3[2]), .LED3(o3[3]),
      .LED4(o3[4]), .LED5(o3[5]), .LED6(o3[6]), .LED7(o3[7]));

   leds #(.PATTERN(8'h55), .ROTATE_EN(1'b1), .DIV(4)) u4 (
      .clk(clk), .rst(r4),
      .LED0(o4[0]), .LED1(o4[1]), .LED2(o4[2]), .LED3(o4[3]),
      .LED4(o4[4]), .LED5(o4[5]), .LED6(o4[6]), .LED7(o4[7]));

   leds #(.PATTERN(8'hFF), .ROTATE_EN(1'b1), .DIV(3)) u5 (
      .clk(clk), .rst(r5),
      .LED0(o5[0]), .LED1(o5[1]), .LED2(o5[2]), .LED3(o5[3]),
      .LED4(o5[4]), .LED5(o5[5]), .LED6(o5[6]), .LED7(o5[7]));

   leds #(.PATTERN(8'hC3), .ROTATE_EN(1'b0), .DIV(5)) u6 (
      .clk(clk), .rst(r6),
      .LED0(o6[0]), .LED1(o6[1]), .LED2(o6[2]), .LED3(o6[3]),
      .LED4(o6[4]), .LED5(o6[5]), .LED6(o6[6]), .LED7(o6[7]));

   task automatic chk(input string tag, input logic [7:0] got,
                      input logic [7:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %02h want %02h", tag, got, exp);
      end
   endtask

   logic [7:0] exp2 [8] = '{8'h02, 8'h04, 8'h08, 8'h10,
                            8'h20, 8'h40, 8'h80, 8'h01};
   logic [7:0] exp3 [8] = '{8'h81, 8'h81, 8'h81, 8'h03,
                            8'h03, 8'h03, 8'h03, 8'h06};

   initial begin
      #1;
      {r1, r2, r3, r4, r5, r6} = 6'b111111;
      #1;
      chk("rst1", o1, 8'h55);
      chk("rst2", o2, 8'h01);
      chk("rst3", o3, 8'h81);
      chk("rst6", o6, 8'hC3);
      repeat (2) @(negedge clk);

      r1 = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("static55", o1, 8'h55);
      end

      r2 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk($sformatf("div1_e%0d", i + 1), o2, exp2[i]);
      end

      r3 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk($sformatf("div4_e%0d", i + 1), o3, exp3[i]);
      end

      r4 = 1'b0;
      repeat (4) @(negedge clk);
      chk("t4_e4", o4, 8'hAA);
      repeat (2) @(negedge clk);
      #2 r4 = 1'b1;
      #1 chk("t4_async", o4, 8'h55);
      @(negedge clk);
      chk("t4_hold", o4, 8'h55);
      r4 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("t4_re%0d", i + 1), o4,
             (i == 3) ? 8'hAA : 8'h55);
      end

      r5 = 1'b0;
      for (int i = 0; i < 48; i++) begin
         @(negedge clk);
         chk("ff_rot", o5, 8'hFF);
      end

      r6 = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         chk("static_c3", o6, 8'hC3);
      end

      $display("End of simulation");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
